// File: rtl/inst_encoder.sv
// Converts field-level instruction requests into 32-bit R/I/J words and writes them to IMEM.
// Optional request checking is enabled by defining ENC_CHECK_EN.
module inst_encoder #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [2:0]        in_alu_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [25:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    // state   | meaning
    // IDLE    | waiting for a request (in_ready unless full or start)
    // WRITE   | encoded word presented to IMEM until mem_ready
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_WRITE = 1'b1;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [5:0]        r_func;
    logic [5:0]        i_op;
    logic [31:0]       enc_word;
    logic              accept;

    always_comb begin
        r_func = 6'b100000;
        i_op   = 6'b001000;
        case (in_alu_op)
            3'b100: begin r_func = 6'b100000; i_op = 6'b001000; end
            3'b101: begin r_func = 6'b100010; i_op = 6'b001000; end
            3'b000: begin r_func = 6'b100100; i_op = 6'b001100; end
            3'b001: begin r_func = 6'b100101; i_op = 6'b001101; end
            3'b010: begin r_func = 6'b100110; i_op = 6'b001110; end
            3'b011: begin r_func = 6'b100111; i_op = 6'b001000; end
            3'b110: begin r_func = 6'b101011; i_op = 6'b001011; end
            3'b111: begin r_func = 6'b000100; i_op = 6'b001000; end
            default: begin r_func = 6'b100000; i_op = 6'b001000; end
        endcase
    end

    always_comb begin
        enc_word = '0;
        case (in_kind)
            3'd0: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, r_func};
            3'd1: enc_word = {i_op, in_rs, in_rt, in_imm[15:0]};
            3'd2: enc_word = {6'b100011, in_rs, in_rt, in_imm[15:0]};
            3'd3: enc_word = {6'b101011, in_rs, in_rt, in_imm[15:0]};
            3'd4: enc_word = {6'b000100, in_rs, in_rt, in_imm[15:0]};
            3'd5: enc_word = {6'b000101, in_rs, in_rt, in_imm[15:0]};
            3'd6: enc_word = {6'b000010, in_imm};
            3'd7: enc_word = {6'b000011, in_imm};
            default: enc_word = '0;
        endcase
    end

    assign full     = (count_q == DEPTH_C);
    assign in_ready = (state_q == S_IDLE) && !start && !full;
    assign accept   = in_valid && in_ready;
    assign mem_we   = (state_q == S_WRITE);
    assign mem_addr = addr_q;
    assign mem_wdata = wdata_q;
    assign count    = count_q;

`ifdef ENC_CHECK_EN
    logic err_q, err_d;
    logic req_illegal;

    // sub, nor and sllv have no immediate form
    assign req_illegal = (in_kind == 3'd1) &&
                         ((in_alu_op == 3'b101) || (in_alu_op == 3'b011) || (in_alu_op == 3'b111));
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        wdata_d = wdata_q;
`ifdef ENC_CHECK_EN
        err_d   = err_q;
`endif
        if (start) begin
            state_d = S_IDLE;
            addr_d  = base_addr;
            count_d = '0;
`ifdef ENC_CHECK_EN
            err_d   = 1'b0;
`endif
        end else if (state_q == S_IDLE) begin
            if (accept) begin
`ifdef ENC_CHECK_EN
                if (req_illegal) begin
                    err_d = 1'b1;
                end else begin
                    wdata_d = enc_word;
                    state_d = S_WRITE;
                end
`else
                wdata_d = enc_word;
                state_d = S_WRITE;
`endif
            end
        end else if (mem_ready) begin
            addr_d  = addr_q + 1'b1;
            count_d = count_q + 1'b1;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            wdata_q <= '0;
`ifdef ENC_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            wdata_q <= wdata_d;
`ifdef ENC_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

endmodule
